// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, Rcon and S-box tables,
// and the GF(2^8) xtime helper.
package aes_encrypt_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0x00 sits in the top byte of the table.
  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return SBOX_TBL[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime_f(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/s_box.sv
// Single AES forward S-box lookup.
module s_box
  import aes_encrypt_iter_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox_f(a_i);

endmodule

// File: rtl/sub_bytes.sv
// SubBytes over the full 128-bit state, one S-box per byte.
module sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    s_box u_s_box (
      .a_i(data_i[127-8*i -: 8]),
      .y_o(data_o[127-8*i -: 8])
    );
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
module aes_encrypt_iter
  import aes_encrypt_iter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] sb_out, sr_out, mc_out, next_key;
  logic [31:0]  w3_rot, w3_sub, key_tmp;
  logic [31:0]  nk0, nk1, nk2, nk3;

  sub_bytes u_sub_bytes (
    .data_i(state_q),
    .data_o(sb_out)
  );

  assign w3_rot = {key_q[23:0], key_q[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_subword
    s_box u_s_box (
      .a_i(w3_rot[31-8*k -: 8]),
      .y_o(w3_sub[31-8*k -: 8])
    );
  end

  assign key_tmp  = w3_sub ^ {rcon_f(rnd_q), 24'h000000};
  assign nk0      = key_q[127:96] ^ key_tmp;
  assign nk1      = key_q[95:64]  ^ nk0;
  assign nk2      = key_q[63:32]  ^ nk1;
  assign nk3      = key_q[31:0]   ^ nk2;
  assign next_key = {nk0, nk1, nk2, nk3};

  // Byte i of the state is row i%4, column i/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_out[127-8*(4*c+r) -: 8] = sb_out[127-8*(4*((c+r)%4)+r) -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_out[127-32*c -: 8];
    assign a1 = sr_out[119-32*c -: 8];
    assign a2 = sr_out[111-32*c -: 8];
    assign a3 = sr_out[103-32*c -: 8];

    assign mc_out[127-32*c -: 8] = xtime_f(a0) ^ xtime_f(a1) ^ a1 ^ a2 ^ a3;
    assign mc_out[119-32*c -: 8] = a0 ^ xtime_f(a1) ^ xtime_f(a2) ^ a2 ^ a3;
    assign mc_out[111-32*c -: 8] = a0 ^ a1 ^ xtime_f(a2) ^ xtime_f(a3) ^ a3;
    assign mc_out[103-32*c -: 8] = xtime_f(a0) ^ a0 ^ a1 ^ a2 ^ xtime_f(a3);
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = data_in ^ key_in;
          key_d   = key_in;
          rnd_d   = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        key_d = next_key;
        if (rnd_q == NUM_ROUNDS) begin
          state_d = sr_out ^ next_key;
          fsm_d   = ST_DONE;
        end else begin
          state_d = mc_out ^ next_key;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign data_out  = state_q;

endmodule
